wb_stage: RTL and testbench

Writeback stage of the five-stage core. Captures the retiring instruction from the memory stage and waits for the data-memory response on loads. Sign/zero-extends and aligns load data, then drives the register file write port (`regf_we`, `rd_addr`, `rd_wdata`, `wb_int_flag`) for exactly one cycle per retired instruction. Also maintains the 64-bit retired-instruction counter and back-pressures the memory stage while a load is outstanding.

---
 rtl/wb_stage.sv | 181 ++++++++++++++++++
 tb/tb_wb_stage.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Writeback stage: captures the retiring instruction, waits for load data, aligns it and
// drives a one-cycle register-file write plus retire pulse; counts retired instructions.
module wb_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mem_valid,
  input  logic            mem_regf_we,
  input  logic [4:0]      mem_rd_addr,
  input  logic [XLEN-1:0] mem_alu_result,
  input  logic            mem_is_load,
  input  logic [2:0]      mem_funct3,
  input  logic            mem_int_instr,
  input  logic            dmem_resp,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            wb_stall,
  output logic            regf_we,
  output logic [4:0]      rd_addr,
  output logic [XLEN-1:0] rd_wdata,
  output logic            wb_int_flag,
  output logic            retire,
  output logic [63:0]     instret
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t state_q, state_d;
  logic   accept, resp_fire, accept_alu;

  logic            ld_we_q, ld_we_d, ld_int_q, ld_int_d;
  logic [4:0]      ld_rd_q, ld_rd_d;
  logic [1:0]      ld_off_q, ld_off_d;
  logic [2:0]      ld_f3_q, ld_f3_d;

  logic            slot_vld_q, slot_vld_d, slot_we_q, slot_we_d, slot_int_q, slot_int_d;
  logic [4:0]      slot_rd_q, slot_rd_d;
  logic [XLEN-1:0] slot_dat_q, slot_dat_d;

  logic            out_we_q, out_we_d, out_ret_q, out_ret_d, out_int_q, out_int_d;
  logic [4:0]      out_rd_q, out_rd_d;
  logic [XLEN-1:0] out_dat_q, out_dat_d;
  logic [63:0]     instret_q, instret_d;

  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (accept)                               state_d = mem_is_load ? S_WAIT : S_IDLE;
    else if (state_q == S_WAIT && dmem_resp)  state_d = S_IDLE;
  end

  always_comb begin
    wb_stall   = (state_q == S_WAIT) && !dmem_resp;
    resp_fire  = (state_q == S_WAIT) && dmem_resp;
    accept     = mem_valid && !wb_stall;
    accept_alu = accept && !mem_is_load;
  end

  always_comb begin
    ld_byte = dmem_rdata[{ld_off_q, 3'b000} +: 8];
    ld_half = ld_off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (ld_f3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'b0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'b0, ld_half};
      default: ld_data = dmem_rdata;
    endcase
  end

  // A non-load accepted while another result owns the output (load response or slot)
  // waits one cycle in the slot; one-in/one-out keeps a single entry sufficient.
  always_comb begin
    out_we_d   = 1'b0;
    out_ret_d  = 1'b0;
    out_int_d  = 1'b0;
    out_rd_d   = out_rd_q;
    out_dat_d  = out_dat_q;
    slot_vld_d = 1'b0;
    slot_we_d  = slot_we_q;
    slot_int_d = slot_int_q;
    slot_rd_d  = slot_rd_q;
    slot_dat_d = slot_dat_q;
    ld_we_d    = ld_we_q;
    ld_int_d   = ld_int_q;
    ld_rd_d    = ld_rd_q;
    ld_off_d   = ld_off_q;
    ld_f3_d    = ld_f3_q;
    instret_d  = out_ret_q ? instret_q + 64'd1 : instret_q;

    if (resp_fire) begin
      out_ret_d = 1'b1;
      out_we_d  = ld_we_q && (ld_rd_q != 5'd0);
      out_rd_d  = ld_rd_q;
      out_dat_d = ld_data;
      out_int_d = ld_int_q;
    end else if (slot_vld_q) begin
      out_ret_d = 1'b1;
      out_we_d  = slot_we_q && (slot_rd_q != 5'd0);
      out_rd_d  = slot_rd_q;
      out_dat_d = slot_dat_q;
      out_int_d = slot_int_q;
    end else if (accept_alu) begin
      out_ret_d = 1'b1;
      out_we_d  = mem_regf_we && (mem_rd_addr != 5'd0);
      out_rd_d  = mem_rd_addr;
      out_dat_d = mem_alu_result;
      out_int_d = mem_int_instr;
    end

    if (accept_alu && (resp_fire || slot_vld_q)) begin
      slot_vld_d = 1'b1;
      slot_we_d  = mem_regf_we;
      slot_int_d = mem_int_instr;
      slot_rd_d  = mem_rd_addr;
      slot_dat_d = mem_alu_result;
    end

    if (accept && mem_is_load) begin
      ld_we_d  = mem_regf_we;
      ld_int_d = mem_int_instr;
      ld_rd_d  = mem_rd_addr;
      ld_off_d = mem_alu_result[1:0];
      ld_f3_d  = mem_funct3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_we_q    <= 1'b0;
      ld_int_q   <= 1'b0;
      ld_rd_q    <= 5'd0;
      ld_off_q   <= 2'd0;
      ld_f3_q    <= 3'd0;
      slot_vld_q <= 1'b0;
      slot_we_q  <= 1'b0;
      slot_int_q <= 1'b0;
      slot_rd_q  <= 5'd0;
      slot_dat_q <= '0;
      out_we_q   <= 1'b0;
      out_ret_q  <= 1'b0;
      out_int_q  <= 1'b0;
      out_rd_q   <= 5'd0;
      out_dat_q  <= '0;
      instret_q  <= 64'd0;
    end else begin
      ld_we_q    <= ld_we_d;
      ld_int_q   <= ld_int_d;
      ld_rd_q    <= ld_rd_d;
      ld_off_q   <= ld_off_d;
      ld_f3_q    <= ld_f3_d;
      slot_vld_q <= slot_vld_d;
      slot_we_q  <= slot_we_d;
      slot_int_q <= slot_int_d;
      slot_rd_q  <= slot_rd_d;
      slot_dat_q <= slot_dat_d;
      out_we_q   <= out_we_d;
      out_ret_q  <= out_ret_d;
      out_int_q  <= out_int_d;
      out_rd_q   <= out_rd_d;
      out_dat_q  <= out_dat_d;
      instret_q  <= instret_d;
    end
  end

  assign regf_we     = out_we_q;
  assign retire      = out_ret_q;
  assign wb_int_flag = out_int_q;
  assign rd_addr     = out_rd_q;
  assign rd_wdata    = out_dat_q;
  assign instret     = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: stimulus pushes expected writeback packets, a negedge
// monitor pops and compares each retire; directed checks cover stall, reset and instret.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_valid, mem_regf_we, mem_is_load, mem_int_instr, dmem_resp;
  logic [4:0]  mem_rd_addr;
  logic [31:0] mem_alu_result, dmem_rdata;
  logic [2:0]  mem_funct3;
  logic        wb_stall, regf_we, wb_int_flag, retire;
  logic [4:0]  rd_addr;
  logic [31:0] rd_wdata;
  logic [63:0] instret;

  int n_cmp = 0;
  int n_bad = 0;
  logic [38:0] exp_q[$];

  always #5 clk = ~clk;

  wb_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_valid(mem_valid), .mem_regf_we(mem_regf_we), .mem_rd_addr(mem_rd_addr),
    .mem_alu_result(mem_alu_result), .mem_is_load(mem_is_load), .mem_funct3(mem_funct3),
    .mem_int_instr(mem_int_instr), .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata),
    .wb_stall(wb_stall), .regf_we(regf_we), .rd_addr(rd_addr), .rd_wdata(rd_wdata),
    .wb_int_flag(wb_int_flag), .retire(retire), .instret(instret)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Packet layout: {int_flag, regf_we, rd_addr, rd_wdata}
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (retire) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_retire: rd=%0d data=0x%0h with empty scoreboard at %0t",
                   rd_addr, rd_wdata, $time);
        end else begin
          chk("retire_pkt", {25'b0, wb_int_flag, regf_we, rd_addr, rd_wdata},
              {25'b0, exp_q.pop_front()});
        end
      end else begin
        chk("idle_pulses", {62'b0, regf_we, wb_int_flag}, 64'd0);
      end
    end
  end

  task automatic drive(input logic we, input logic [4:0] rd, input logic [31:0] res,
                       input logic ld, input logic [2:0] f3, input logic intr);
    mem_valid      = 1'b1;
    mem_regf_we    = we;
    mem_rd_addr    = rd;
    mem_alu_result = res;
    mem_is_load    = ld;
    mem_funct3     = f3;
    mem_int_instr  = intr;
  endtask

  task automatic alu(input logic we, input logic [4:0] rd, input logic [31:0] res,
                     input logic intr);
    exp_q.push_back({intr, we && (rd != 5'd0), rd, res});
    drive(we, rd, res, 1'b0, 3'b000, intr);
    @(posedge clk); #1;
  endtask

  // Load accepted at one edge, response sampled at the very next edge.
  task automatic load(input logic [4:0] rd, input logic [31:0] addr, input logic [2:0] f3,
                      input logic [31:0] rdata, input logic [31:0] expdata);
    drive(1'b1, rd, addr, 1'b1, f3, 1'b0);
    @(posedge clk); #1;
    mem_valid  = 1'b0;
    exp_q.push_back({1'b0, rd != 5'd0, rd, expdata});
    dmem_resp  = 1'b1;
    dmem_rdata = rdata;
    @(posedge clk); #1;
    dmem_resp  = 1'b0;
  endtask

  task automatic idle(input int n);
    mem_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    dmem_resp  = 1'b0;
    dmem_rdata = 32'h0;
    drive(1'b1, 5'd3, 32'h55, 1'b0, 3'b000, 1'b0);

    // Reset held with a valid instruction present
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_strobes", {61'b0, regf_we, retire, wb_int_flag}, 64'd0);
    chk("rst_rd_addr", {59'b0, rd_addr}, 64'd0);
    chk("rst_rd_wdata", {32'b0, rd_wdata}, 64'd0);
    chk("rst_instret", instret, 64'd0);
    chk("rst_stall", {63'b0, wb_stall}, 64'd0);
    exp_q.push_back({1'b0, 1'b1, 5'd3, 32'h55});
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    mem_valid = 1'b0;
    @(negedge clk);
    chk("first_accept_retire", {63'b0, retire}, 64'd1);
    @(posedge clk); #1;

    // ALU burst, back-to-back, including x0 destination
    alu(1'b1, 5'd5, 32'h11, 1'b0);
    alu(1'b1, 5'd6, 32'h22, 1'b0);
    alu(1'b1, 5'd0, 32'h33, 1'b0);
    idle(2);
    chk("instret_burst", instret, 64'd4);

    // Load widths on 0x80FF7F01
    load(5'd10, 32'h1003, 3'b000, 32'h80FF7F01, 32'hFFFFFF80);
    load(5'd11, 32'h1001, 3'b100, 32'h80FF7F01, 32'h0000007F);
    load(5'd12, 32'h1002, 3'b001, 32'h80FF7F01, 32'hFFFF80FF);
    load(5'd13, 32'h1000, 3'b101, 32'h80FF7F01, 32'h00007F01);
    load(5'd14, 32'h1000, 3'b010, 32'h80FF7F01, 32'h80FF7F01);
    idle(2);
    chk("instret_loads", instret, 64'd9);

    // Load stall: response four cycles after accept, next instruction rides the response edge
    drive(1'b1, 5'd7, 32'h100, 1'b1, 3'b010, 1'b0);
    @(posedge clk); #1;
    mem_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stall_high", {63'b0, wb_stall}, 64'd1);
      @(posedge clk); #1;
    end
    exp_q.push_back({1'b0, 1'b1, 5'd7, 32'hDEADBEEF});
    exp_q.push_back({1'b0, 1'b1, 5'd8, 32'h99});
    dmem_resp  = 1'b1;
    dmem_rdata = 32'hDEADBEEF;
    drive(1'b1, 5'd8, 32'h99, 1'b0, 3'b000, 1'b0);
    #1;
    chk("stall_low_on_resp", {63'b0, wb_stall}, 64'd0);
    @(posedge clk); #1;
    dmem_resp = 1'b0;
    mem_valid = 1'b0;
    @(negedge clk);
    chk("load_retire_addr", {58'b0, retire, rd_addr}, {58'b0, 1'b1, 5'd7});
    @(negedge clk);
    chk("next_retire_addr", {58'b0, retire, rd_addr}, {58'b0, 1'b1, 5'd8});
    idle(2);
    chk("instret_stall", instret, 64'd11);

    // Interrupt tag followed by a normal instruction
    alu(1'b1, 5'd1, 32'hAB, 1'b1);
    alu(1'b1, 5'd2, 32'hCD, 1'b0);
    idle(2);
    chk("instret_int", instret, 64'd13);

    // Reset while waiting for a load; later response must be ignored
    drive(1'b1, 5'd9, 32'h200, 1'b1, 3'b010, 1'b0);
    @(posedge clk); #1;
    mem_valid = 1'b0;
    @(negedge clk);
    chk("wait_stall", {63'b0, wb_stall}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_in_wait_stall", {63'b0, wb_stall}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    dmem_resp  = 1'b1;
    dmem_rdata = 32'h12345678;
    @(posedge clk); #1;
    dmem_resp = 1'b0;
    idle(3);
    @(negedge clk);
    chk("instret_after_rst", instret, 64'd0);
    chk("no_strobe_after_rst", {62'b0, regf_we, retire}, 64'd0);

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
